multicycle_ctrl: RTL and testbench

Multicycle RISC-V control unit: the sequencer that drives the ALU's `alucontrol` encoding and consumes its `zero`/`emaior` flags to resolve branches. It sits beside the datapath. It decodes the opcode latched in the instruction register and steps a Moore FSM through fetch, decode, execute, memory and writeback, asserting one cycle's worth of datapath selects and write enables per state. Branch-taken is the only flag-dependent (Mealy) output.

---
 rtl/multicycle_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control unit for a multicycle RISC-V datapath.
// A Moore FSM steps through fetch, decode, execute, memory and writeback.
// It drives datapath selects, write enables and the ALU operation code.
// The only output that depends on the ALU flags is pcwrite in the branch state.
//
// Optional feature: define BRANCH_EXT_EN to make bne, blt and bge taken.
// When it is undefined, only beq can be taken.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_ni       synchronous active-low reset
//   op_i           instruction[6:0]
//   funct3_i       instruction[14:12]
//   funct7b5_i     instruction[30]
//   zero_i         ALU result == 0
//   emaior_i       ALU sum non-negative and non-zero
//   pcwrite_o      PC enable
//   adrsrc_o       memory address select (0 PC, 1 ALUOut)
//   memwrite_o     data memory write enable
//   irwrite_o      instruction register enable
//   regwrite_o     register file write enable
//   resultsrc_o    00 ALUOut, 01 memory data, 10 ALU result
//   alusrca_o      00 PC, 01 OldPC, 10 rs1
//   alusrcb_o      00 rs2, 01 ImmExt, 10 constant 4
//   immsrc_o       00 I, 01 S, 10 B, 11 J
//   alucontrol_o   000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt, 110 srl, 111 xor
module multicycle_ctrl (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       emaior_i,
    output logic       pcwrite_o,
    output logic       adrsrc_o,
    output logic       memwrite_o,
    output logic       irwrite_o,
    output logic       regwrite_o,
    output logic [1:0] resultsrc_o,
    output logic [1:0] alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] immsrc_o,
    output logic [2:0] alucontrol_o
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecR, StExecI, StAluWb, StBranch, StJal
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    state_e     state_q, state_d;
    logic [1:0] aluop;
    logic       branch_taken;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (op_i)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    default:         state_d = StFetch;  // unknown op acts as a NOP
                endcase
            end
            StMemAdr:   state_d = (op_i == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StExecR, StExecI, StJal: state_d = StAluWb;
            StMemWb, StMemWrite, StAluWb, StBranch: state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    // Flags come from rs1 - rs2; signed overflow is deliberately not corrected.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3_i)
            3'b000:  branch_taken = zero_i;
`ifdef BRANCH_EXT_EN
            3'b001:  branch_taken = ~zero_i;
            3'b100:  branch_taken = ~zero_i & ~emaior_i;
            3'b101:  branch_taken = zero_i | emaior_i;
`endif
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        pcwrite_o    = 1'b0;
        adrsrc_o     = 1'b0;
        memwrite_o   = 1'b0;
        irwrite_o    = 1'b0;
        regwrite_o   = 1'b0;
        resultsrc_o  = 2'b00;
        alusrca_o    = 2'b00;
        alusrcb_o    = 2'b00;
        aluop        = 2'b00;
        alucontrol_o = 3'b000;

        unique case (state_q)
            StFetch: begin
                irwrite_o   = 1'b1;
                pcwrite_o   = 1'b1;
                alusrcb_o   = 2'b10;
                resultsrc_o = 2'b10;
            end
            StDecode: begin
                alusrca_o = 2'b01;  // OldPC + imm: branch target lands in ALUOut
                alusrcb_o = 2'b01;
            end
            StMemAdr: begin
                alusrca_o = 2'b10;
                alusrcb_o = 2'b01;
            end
            StMemRead:  adrsrc_o = 1'b1;
            StMemWb: begin
                resultsrc_o = 2'b01;
                regwrite_o  = 1'b1;
            end
            StMemWrite: begin
                adrsrc_o   = 1'b1;
                memwrite_o = 1'b1;
            end
            StExecR: begin
                alusrca_o = 2'b10;
                aluop     = 2'b10;
            end
            StExecI: begin
                alusrca_o = 2'b10;
                alusrcb_o = 2'b01;
                aluop     = 2'b10;
            end
            StAluWb:    regwrite_o = 1'b1;
            StBranch: begin
                alusrca_o = 2'b10;
                aluop     = 2'b01;
                pcwrite_o = branch_taken;
            end
            StJal: begin
                alusrca_o = 2'b01;
                alusrcb_o = 2'b10;
                pcwrite_o = 1'b1;
            end
            default: ;
        endcase

        case (aluop)
            2'b01:   alucontrol_o = 3'b001;
            2'b10: begin
                case (funct3_i)
                    3'b000:  alucontrol_o = (op_i[5] & funct7b5_i) ? 3'b001 : 3'b000;
                    3'b001:  alucontrol_o = 3'b100;
                    3'b010:  alucontrol_o = 3'b101;
                    3'b100:  alucontrol_o = 3'b111;
                    3'b101:  alucontrol_o = 3'b110;
                    3'b110:  alucontrol_o = 3'b011;
                    3'b111:  alucontrol_o = 3'b010;
                    default: alucontrol_o = 3'b000;
                endcase
            end
            default: alucontrol_o = 3'b000;
        endcase

        // In reset, any in-flight instruction is abandoned: no writes, fetch-like selects.
        if (!reset_ni) begin
            pcwrite_o    = 1'b0;
            adrsrc_o     = 1'b0;
            memwrite_o   = 1'b0;
            irwrite_o    = 1'b0;
            regwrite_o   = 1'b0;
            resultsrc_o  = 2'b10;
            alusrca_o    = 2'b00;
            alusrcb_o    = 2'b10;
            alucontrol_o = 3'b000;
        end
    end

    always_comb begin
        case (op_i)
            OpStore:  immsrc_o = 2'b01;
            OpBranch: immsrc_o = 2'b10;
            OpJal:    immsrc_o = 2'b11;
            default:  immsrc_o = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed steps then randomized instructions,
// each cycle compared against a phase-table model of the control outputs.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       emaior = 1'b0;

    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .op_i         (op),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .zero_i       (zero),
        .emaior_i     (emaior),
        .pcwrite_o    (pcwrite),
        .adrsrc_o     (adrsrc),
        .memwrite_o   (memwrite),
        .irwrite_o    (irwrite),
        .regwrite_o   (regwrite),
        .resultsrc_o  (resultsrc),
        .alusrca_o    (alusrca),
        .alusrcb_o    (alusrcb),
        .immsrc_o     (immsrc),
        .alucontrol_o (alucontrol)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b001:  return 3'b100;
            3'b010:  return 3'b101;
            3'b100:  return 3'b111;
            3'b101:  return 3'b110;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic g);
        if (f3 == 3'b000) return z;
`ifdef BRANCH_EXT_EN
        if (f3 == 3'b001) return !z;
        if (f3 == 3'b100) return !z && !g;
        if (f3 == 3'b101) return z || g;
`endif
        return 1'b0;
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Expected outputs packed as {pc, adr, mw, ir, rw, res[2], a[2], b[2], imm[2], alu[3]}.
    function automatic logic [15:0] ref_vec(input string ph);
        logic pc = 0, adr = 0, mw = 0, ir = 0, rw = 0;
        logic [1:0] res = 0, a = 0, b = 0;
        logic [2:0] alu = 0;
        case (ph)
            "reset":   begin res = 2'b10; b = 2'b10; end
            "fetch":   begin ir = 1; pc = 1; b = 2'b10; res = 2'b10; end
            "decode":  begin a = 2'b01; b = 2'b01; end
            "memadr":  begin a = 2'b10; b = 2'b01; end
            "memread": adr = 1;
            "memwb":   begin res = 2'b01; rw = 1; end
            "memwrite": begin adr = 1; mw = 1; end
            "execr":   begin a = 2'b10; alu = ref_alu(op, funct3, funct7b5); end
            "execi":   begin a = 2'b10; b = 2'b01; alu = ref_alu(op, funct3, funct7b5); end
            "aluwb":   rw = 1;
            "branch":  begin a = 2'b10; alu = 3'b001; pc = ref_taken(funct3, zero, emaior); end
            "jal":     begin a = 2'b01; b = 2'b10; pc = 1; end
            default:   ;
        endcase
        return {pc, adr, mw, ir, rw, res, a, b, ref_imm(op), alu};
    endfunction

    // One clock: drive flags, compare at the falling edge, leave just after the next rise.
    task automatic cycle(input string ph, input string tag, input logic rnd,
                         input logic z, input logic g);
        logic [15:0] exp_v, act_v;
        if (rnd) begin
            zero   = 1'($urandom);
            emaior = 1'($urandom);
        end else begin
            zero   = z;
            emaior = g;
        end
        @(negedge clk);
        exp_v = ref_vec(ph);
        act_v = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb,
                 immsrc, alucontrol};
        n_tests++;
        assert (act_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %h expected %h", tag, ph, act_v, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction; abort_at >= 0 asserts reset in that phase and abandons it.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic rnd, input logic z, input logic g,
                             input int abort_at);
        string seq[$];
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        case (o)
            7'b0000011: seq = '{"fetch", "decode", "memadr", "memread", "memwb"};
            7'b0100011: seq = '{"fetch", "decode", "memadr", "memwrite"};
            7'b0110011: seq = '{"fetch", "decode", "execr", "aluwb"};
            7'b0010011: seq = '{"fetch", "decode", "execi", "aluwb"};
            7'b1100011: seq = '{"fetch", "decode", "branch"};
            7'b1101111: seq = '{"fetch", "decode", "jal", "aluwb"};
            default:    seq = '{"fetch", "decode"};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            if (i == abort_at) begin
                reset_n = 1'b0;
                cycle("reset", tag, rnd, z, g);
                reset_n = 1'b1;
                return;
            end
            cycle(seq[i], tag, rnd, z, g);
        end
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [6:0] o;
        int abort_at;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                7'b0000000};

        // Reset held three cycles, with a varying op on the bus.
        for (int i = 0; i < 3; i++) begin
            op = 7'($urandom);
            cycle("reset", "rst_hold", 1'b1, 1'b0, 1'b0);
        end
        reset_n = 1'b1;

        run_instr("rtype_sub", 7'b0110011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        run_instr("itype_xor", 7'b0010011, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run_instr("itype_add_f7", 7'b0010011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        run_instr("beq_not", 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        run_instr("blt_00", 7'b1100011, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_instr("bne_0", 7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_instr("bge_g", 7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run_instr("unknown", 7'b1111111, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run_instr("sw_abort", 7'b0100011, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        run_instr("after_abort", 7'b0110011, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            o = ops[$urandom_range(0, 6)];
            if (o == 7'b0000000) o = 7'($urandom);
            abort_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr("random", o, 3'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0, abort_at);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
